// File: rtl/word_gather_if.sv
// Word-gather handshake bundle: upstream word stream in, assembled bundle out.
// Latency: none, pure wiring between producer, gather block and consumer.
// Backpressure: in_ready/out_ready are carried unchanged between the endpoints.
interface word_gather_if #(
  parameter int s = 3,
  parameter int n = 16
);
  localparam int l = 2**s;

  logic           in_valid;
  logic           in_ready;
  logic [n-1:0]   in_data;
  logic           in_last;
  logic           out_valid;
  logic           out_ready;
  logic [l*n-1:0] out_data;
  logic [s:0]     out_count;
  logic [l-1:0]   out_mask;

  // Environment side: produces words, consumes bundles.
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count, out_mask
  );

  // Gather block side: consumes words, produces bundles.
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count, out_mask
  );
endinterface

// File: rtl/word_gather.sv
// Gathers up to 2**s n-bit words into one bundle; in_last closes a bundle early.
// Latency: out_valid rises the cycle after the closing word; no same-cycle refill.
// Backpressure: in_ready drops while a bundle is held; the hold lasts until out_ready.
module word_gather #(
  parameter int s = 3,
  parameter int n = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          gwe,
  word_gather_if.slave  bus
);
  localparam int l = 2**s;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [s-1:0]   idx_q, idx_d;
  logic [l*n-1:0] slots_q, slots_d;
  logic [s:0]     count_q, count_d;
  logic [l-1:0]   mask_q, mask_d;

  logic in_xfer;
  logic out_xfer;
  logic close_bundle;

  // Handshakes and outputs come straight from registers.
  assign bus.in_ready  = (state_q == FILL);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_data  = slots_q;
  assign bus.out_count = count_q;
  assign bus.out_mask  = mask_q;

  // Next-state logic: slot write on input transfer, full clear on output transfer.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    slots_d = slots_q;
    count_d = count_q;
    mask_d  = mask_q;

    in_xfer      = bus.in_valid  && (state_q == FILL) && gwe && rst;
    out_xfer     = bus.out_ready && (state_q == HOLD) && gwe && rst;
    close_bundle = (idx_q == s'(l-1)) || bus.in_last;

    if (in_xfer) begin
      // One-hot slot select from idx; unselected slots keep their value.
      for (int i = 0; i < l; i++) begin
        if (idx_q == s'(i)) begin
          slots_d[i*n +: n] = bus.in_data;
        end
      end
      if (close_bundle) begin
        // idx is left in place; the output transfer resets it.
        state_d = HOLD;
        count_d = {1'b0, idx_q} + (s+1)'(1);
        for (int i = 0; i < l; i++) begin
          mask_d[i] = (s'(i) <= idx_q);
        end
      end else begin
        idx_d = idx_q + s'(1);
      end
    end

    if (out_xfer) begin
      state_d = FILL;
      idx_d   = '0;
      slots_d = '0;
      count_d = '0;
      mask_d  = '0;
    end
  end

  // State register with synchronous active-low reset that discards any bundle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= FILL;
      idx_q   <= '0;
      slots_q <= '0;
      count_q <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      slots_q <= slots_d;
      count_q <= count_d;
      mask_q  <= mask_d;
    end
  end
endmodule

// File: tb/tb_word_gather.sv
// Directed bench for word_gather with s=2, n=8 (four byte slots).
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: exercised by holding out_ready low while a bundle is held.
module tb_word_gather;
  logic clk;
  logic rst;
  logic gwe;

  int n_checks;
  int n_errors;

  word_gather_if #(.s(2), .n(8)) bus ();

  word_gather #(.s(2), .n(8)) dut (
    .clk (clk),
    .rst (rst),
    .gwe (gwe),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    cycle();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic chk_bundle(input string tag, input logic [31:0] data,
                            input logic [2:0] cnt, input logic [3:0] mask);
    chk({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    chk({tag, "_ready"}, 64'(bus.in_ready), 64'd0);
    chk({tag, "_data"},  64'(bus.out_data), 64'(data));
    chk({tag, "_count"}, 64'(bus.out_count), 64'(cnt));
    chk({tag, "_mask"},  64'(bus.out_mask), 64'(mask));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 64'(bus.out_valid), 64'd0);
    chk({tag, "_ready"}, 64'(bus.in_ready), 64'd1);
    chk({tag, "_data"},  64'(bus.out_data), 64'd0);
    chk({tag, "_count"}, 64'(bus.out_count), 64'd0);
    chk({tag, "_mask"},  64'(bus.out_mask), 64'd0);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    rst           = 1'b0;
    gwe           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    cycle();
    cycle();
    rst = 1'b1;
    chk_idle("reset");

    // Full bundle, consumer always ready.
    bus.out_ready = 1'b1;
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    chk("full_mid_ready", 64'(bus.in_ready), 64'd1);
    chk("full_mid_valid", 64'(bus.out_valid), 64'd0);
    send(8'h33, 1'b0);
    send(8'h44, 1'b0);
    chk_bundle("full", 32'h44332211, 3'd4, 4'b1111);
    cycle();
    chk_idle("full_release");

    // Early close, then backpressure with a junk word offered upstream.
    bus.out_ready = 1'b0;
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b1);
    chk_bundle("early", 32'h0000BBAA, 3'd2, 4'b0011);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("bp_data",  64'(bus.out_data), 64'h0000BBAA);
      chk("bp_ready", 64'(bus.in_ready), 64'd0);
      chk("bp_valid", 64'(bus.out_valid), 64'd1);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    cycle();
    chk_idle("bp_release");
    bus.out_ready = 1'b0;
    send(8'h01, 1'b1);
    chk_bundle("bp_next", 32'h00000001, 3'd1, 4'b0001);
    bus.out_ready = 1'b1;
    cycle();
    chk_idle("bp_next_release");

    // Global write enable gating in FILL and in HOLD.
    bus.out_ready = 1'b1;
    send(8'h55, 1'b0);
    gwe          = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h66;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("gwe_fill_ready", 64'(bus.in_ready), 64'd1);
    end
    bus.in_valid = 1'b0;
    gwe          = 1'b1;
    send(8'h77, 1'b1);
    chk_bundle("gwe", 32'h00007755, 3'd2, 4'b0011);
    gwe = 1'b0;
    cycle();
    chk("gwe_hold_valid", 64'(bus.out_valid), 64'd1);
    chk("gwe_hold_data",  64'(bus.out_data), 64'h00007755);
    gwe = 1'b1;
    cycle();
    chk_idle("gwe_release");

    // Reset mid-fill with a word offered during reset.
    send(8'hDE, 1'b0);
    send(8'hAD, 1'b0);
    rst          = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hEE;
    cycle();
    bus.in_valid = 1'b0;
    rst          = 1'b1;
    chk_idle("rst_fill");
    bus.out_ready = 1'b0;
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    send(8'h03, 1'b0);
    send(8'h04, 1'b0);
    chk_bundle("rst_fill_next", 32'h04030201, 3'd4, 4'b1111);

    // Reset mid-hold overrides a simultaneous output transfer.
    bus.out_ready = 1'b1;
    rst           = 1'b0;
    cycle();
    rst = 1'b1;
    chk_idle("rst_hold");

    // in_last on the final slot behaves like a plain full bundle.
    bus.out_ready = 1'b1;
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    send(8'h44, 1'b1);
    chk_bundle("last4", 32'h44332211, 3'd4, 4'b1111);
    cycle();
    chk_idle("last4_release");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
